// File: rtl/rect_linear_grad.sv
// rect_linear_grad: ReLU derivative gate for the backward pass.
// Stores one mask bit per forward activation and gates incoming gradients in the same FIFO order.
module rect_linear_grad #(
  parameter int NN_WIDTH   = 32,
  parameter int MASK_DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                fwd_valid,
  input  logic [NN_WIDTH-1:0] fwd_in,
  output logic                fwd_ready,
  input  logic                grad_in_valid,
  input  logic [NN_WIDTH-1:0] grad_in,
  output logic                grad_in_ready,
  output logic                grad_out_valid,
  output logic [NN_WIDTH-1:0] grad_out,
  input  logic                grad_out_ready,
  output logic [ADDR_WIDTH:0] mask_count
);

  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH+1)'(MASK_DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic                  mask_mem [MASK_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  out_valid_reg, out_valid_next;
  logic [NN_WIDTH-1:0]   out_data_reg, out_data_next;
  logic                  push, pop, fwd_mask, rd_mask;

  // Derivative of ReLU: 1 only for strictly positive pre-activations.
  assign fwd_mask      = !fwd_in[NN_WIDTH-1] && (fwd_in != '0);
  assign fwd_ready     = (count_reg != COUNT_FULL);
  assign grad_in_ready = (count_reg != '0) && (!out_valid_reg || grad_out_ready);
  assign push          = fwd_valid && fwd_ready;
  assign pop           = grad_in_valid && grad_in_ready;
  assign rd_mask       = mask_mem[rd_ptr_reg];

  // Contents need no clear: validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mask_mem[wr_ptr_reg] <= fwd_mask;
    end
  end

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    if (flush) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      out_valid_next = 1'b0;
      out_data_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_next    = rd_ptr_reg + PTR_ONE;
        out_valid_next = 1'b1;
        out_data_next  = rd_mask ? grad_in : '0;
      end else if (out_valid_reg && grad_out_ready) begin
        out_valid_next = 1'b0;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + COUNT_ONE;
        2'b01:   count_next = count_reg - COUNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

  assign grad_out_valid = out_valid_reg;
  assign grad_out       = out_data_reg;
  assign mask_count     = count_reg;

endmodule

// File: tb/tb_rect_linear_grad.sv
// Testbench for rect_linear_grad: random and directed traffic against a queue-based reference model.
module tb_rect_linear_grad;
  localparam int W = 32;
  localparam int D = 64;
  localparam int A = 6;

  logic         clock = 1'b0;
  logic         reset, flush, fwd_valid, fwd_ready;
  logic         grad_in_valid, grad_in_ready, grad_out_valid, grad_out_ready;
  logic [W-1:0] fwd_in, grad_in, grad_out;
  logic [A:0]   mask_count;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending masks plus the output register.
  bit           mq[$];
  bit           m_valid;
  logic [W-1:0] m_out;
  bit           exp_fr, exp_gr, obs_fr, obs_gr;

  always #5 clock = ~clock;

  rect_linear_grad #(.NN_WIDTH(W), .MASK_DEPTH(D), .ADDR_WIDTH(A)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_in(fwd_in), .fwd_ready(fwd_ready),
    .grad_in_valid(grad_in_valid), .grad_in(grad_in), .grad_in_ready(grad_in_ready),
    .grad_out_valid(grad_out_valid), .grad_out(grad_out), .grad_out_ready(grad_out_ready),
    .mask_count(mask_count)
  );

  function automatic bit mask_of(logic [W-1:0] v);
    return $signed(v) > 0;
  endfunction

  function automatic logic [W-1:0] rv();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return W'($urandom_range(1, 32'h7fff_ffff));
      2:       return W'($urandom_range(32'h8000_0000, 32'hffff_ffff));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic model_clear();
    mq.delete();
    m_valid = 1'b0;
    m_out   = '0;
  endtask

  // One clock cycle: drive at negedge, snapshot pre-edge readiness, update model at posedge,
  // return at the next negedge so callers compare settled outputs.
  task automatic step(bit fv, logic [W-1:0] fi, bit gv, logic [W-1:0] gi, bit gr, bit fl = 1'b0);
    bit push, pop, m;
    flush = fl; fwd_valid = fv; fwd_in = fi;
    grad_in_valid = gv; grad_in = gi; grad_out_ready = gr;
    #1;
    exp_fr = (mq.size() != D);
    exp_gr = (mq.size() != 0) && (!m_valid || gr);
    obs_fr = fwd_ready;
    obs_gr = grad_in_ready;
    push = fv && exp_fr;
    pop  = gv && exp_gr;
    @(posedge clock);
    if (fl) begin
      model_clear();
    end else begin
      if (pop) begin
        m = mq.pop_front();
        m_out = m ? gi : '0;
        m_valid = 1'b1;
      end else if (m_valid && gr) begin
        m_valid = 1'b0;
      end
      if (push) mq.push_back(mask_of(fi));
    end
    @(negedge clock);
    flush = 1'b0; fwd_valid = 1'b0; grad_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    grad_in_valid = 1'b1;
    #1;
    checks++;
    if (mask_count !== 0 || grad_out_valid !== 1'b0 || grad_out !== '0 || fwd_ready !== 1'b1 || grad_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%0b out=%h fwd_ready=%0b gin_ready=%0b, required 0 0 0 1 0",
               mask_count, grad_out_valid, grad_out, fwd_ready, grad_in_ready);
    end
    grad_in_valid = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    logic [W-1:0] fv[4] = '{32'd5, 32'hFFFF_FFFD, 32'd0, 32'd7};
    logic [W-1:0] gv[4] = '{32'd10, 32'd20, 32'd30, 32'd40};
    logic [W-1:0] ev[4] = '{32'd10, 32'd0, 32'd0, 32'd40};
    for (int i = 0; i < 4; i++) step(1, fv[i], 0, '0, 1);
    checks++;
    if (mask_count !== 4) begin
      errors++; $display("FAIL basic_count: got %0d, required 4", mask_count);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 1, gv[i], 1);
      checks++;
      if (obs_gr !== 1'b1 || grad_out_valid !== 1'b1 || grad_out !== ev[i]) begin
        errors++;
        $display("FAIL basic_grad%0d: ready=%0b valid=%0b out=%0d, required 1 1 %0d", i, obs_gr, grad_out_valid, grad_out, ev[i]);
      end
      $display("basic: grad_in=%0d grad_out=%0d", gv[i], grad_out);
    end
    step(0, '0, 0, '0, 1);
    checks++;
    if (mask_count !== 0 || grad_out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain: count=%0d valid=%0b, required 0 0", mask_count, grad_out_valid);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < D; i++) step(1, W'($urandom_range(1, 32'h7fff_ffff)), 0, '0, 1);
    checks++;
    if (mask_count !== D || fwd_ready !== 1'b0) begin
      errors++; $display("FAIL full_state: count=%0d fwd_ready=%0b, required 64 0", mask_count, fwd_ready);
    end
    step(1, 32'd9, 0, '0, 1);
    checks++;
    if (obs_fr !== 1'b0 || mask_count !== D) begin
      errors++; $display("FAIL full_reject: fwd_ready=%0b count=%0d, required 0 64", obs_fr, mask_count);
    end
    step(1, 32'd9, 1, W'($urandom), 1);
    checks++;
    if (obs_fr !== 1'b0 || mask_count !== 63 || fwd_ready !== 1'b1 || grad_out !== m_out) begin
      errors++;
      $display("FAIL full_pop: fr_in_pop=%0b count=%0d fr_after=%0b out=%h, required 0 63 1 %h", obs_fr, mask_count, fwd_ready, grad_out, m_out);
    end
    for (int i = 0; i < 63; i++) begin
      step(0, '0, 1, W'($urandom), 1);
      checks++;
      if (grad_out_valid !== 1'b1 || grad_out !== m_out) begin
        errors++; $display("FAIL full_drain%0d: valid=%0b out=%h, required 1 %h", i, grad_out_valid, grad_out, m_out);
      end
    end
    step(0, '0, 0, '0, 1);
    $display("full: drained, count=%0d", mask_count);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    for (int i = 0; i < 4; i++) step(1, rv(), 0, '0, 1);
    step(0, '0, 1, W'($urandom), 0);
    checks++;
    if (grad_out_valid !== 1'b1 || grad_out !== m_out) begin
      errors++; $display("FAIL bp_first: valid=%0b out=%h, required 1 %h", grad_out_valid, grad_out, m_out);
    end
    held = m_out;
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1, W'($urandom), 0);
      checks++;
      if (obs_gr !== 1'b0 || grad_out_valid !== 1'b1 || grad_out !== held || mask_count !== 3) begin
        errors++;
        $display("FAIL bp_hold%0d: ready=%0b valid=%0b out=%h count=%0d, required 0 1 %h 3", i, obs_gr, grad_out_valid, grad_out, mask_count, held);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1, W'($urandom), 1);
      checks++;
      if (obs_gr !== 1'b1 || grad_out_valid !== 1'b1 || grad_out !== m_out || mask_count !== mq.size()) begin
        errors++;
        $display("FAIL bp_release%0d: ready=%0b valid=%0b out=%h count=%0d, required 1 1 %h %0d", i, obs_gr, grad_out_valid, grad_out, mask_count, m_out, mq.size());
      end
    end
    step(0, '0, 0, '0, 1);
    checks++;
    if (grad_out_valid !== 1'b0 || grad_out !== m_out) begin
      errors++; $display("FAIL bp_idle: valid=%0b out=%h, required 0 %h", grad_out_valid, grad_out, m_out);
    end
    $display("backpressure: held=%h final=%h", held, grad_out);
  endtask

  task automatic test_wrap();
    step(0, '0, 0, '0, 1, 1);
    for (int i = 0; i < 62; i++) step(1, rv(), 0, '0, 1);
    for (int i = 0; i < 62; i++) step(0, '0, 1, W'($urandom), 1);
    for (int i = 0; i < 10; i++) step(1, rv(), 0, '0, 1);
    checks++;
    if (mask_count !== 10) begin
      errors++; $display("FAIL wrap_fill: count=%0d, required 10", mask_count);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, rv(), 1, W'($urandom), 1);
      checks++;
      if (obs_fr !== 1'b1 || obs_gr !== 1'b1 || mask_count !== 10 || grad_out !== m_out) begin
        errors++;
        $display("FAIL wrap_pushpop%0d: fr=%0b gr=%0b count=%0d out=%h, required 1 1 10 %h", i, obs_fr, obs_gr, mask_count, grad_out, m_out);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(0, '0, 1, W'($urandom), 1);
      checks++;
      if (grad_out_valid !== 1'b1 || grad_out !== m_out) begin
        errors++; $display("FAIL wrap_drain%0d: valid=%0b out=%h, required 1 %h", i, grad_out_valid, grad_out, m_out);
      end
    end
    step(0, '0, 0, '0, 1);
    $display("wrap: count=%0d", mask_count);
  endtask

  task automatic test_empty();
    logic [W-1:0] g;
    step(0, '0, 1, W'($urandom), 1);
    checks++;
    if (obs_gr !== 1'b0 || grad_out_valid !== 1'b0) begin
      errors++; $display("FAIL empty_stall: ready=%0b valid=%0b, required 0 0", obs_gr, grad_out_valid);
    end
    step(1, 32'd100, 1, W'($urandom), 1);
    checks++;
    if (obs_gr !== 1'b0 || mask_count !== 1) begin
      errors++; $display("FAIL empty_nobypass: ready=%0b count=%0d, required 0 1", obs_gr, mask_count);
    end
    g = W'($urandom);
    step(0, '0, 1, g, 1);
    checks++;
    if (obs_gr !== 1'b1 || grad_out_valid !== 1'b1 || grad_out !== g) begin
      errors++; $display("FAIL empty_next: ready=%0b valid=%0b out=%h, required 1 1 %h", obs_gr, grad_out_valid, grad_out, g);
    end
    $display("empty: grad_in=%h grad_out=%h", g, grad_out);
    step(0, '0, 0, '0, 1);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rv(), $urandom_range(0, 2) != 0, W'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
      checks++;
      if (obs_fr !== exp_fr || obs_gr !== exp_gr || grad_out_valid !== m_valid ||
          grad_out !== m_out || mask_count !== mq.size()) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL random%0d: fr=%0b gr=%0b valid=%0b out=%h count=%0d, required %0b %0b %0b %h %0d",
                   i, obs_fr, obs_gr, grad_out_valid, grad_out, mask_count, exp_fr, exp_gr, m_valid, m_out, mq.size());
      end
    end
    $display("random: 600 cycles, final count=%0d", mask_count);
  endtask

  task automatic test_reset_midstream();
    step(0, '0, 0, '0, 1, 1);
    for (int i = 0; i < 8; i++) step(1, W'($urandom_range(1, 1000)), 0, '0, 1);
    step(0, '0, 1, W'($urandom), 0);
    checks++;
    if (grad_out_valid !== 1'b1 || mask_count !== 7) begin
      errors++; $display("FAIL mid_setup: valid=%0b count=%0d, required 1 7", grad_out_valid, mask_count);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mask_count !== 0 || grad_out_valid !== 1'b0 || grad_out !== '0 || fwd_ready !== 1'b1 || grad_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d valid=%0b out=%h fr=%0b gr=%0b, required 0 0 0 1 0", mask_count, grad_out_valid, grad_out, fwd_ready, grad_in_ready);
    end
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) step(1, W'($urandom_range(1, 1000)), 0, '0, 1);
    step(0, '0, 1, W'($urandom), 0);
    step(1, 32'd5, 1, W'($urandom), 0, 1);
    checks++;
    if (mask_count !== 0 || grad_out_valid !== 1'b0 || grad_out !== '0 || fwd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_flush: count=%0d valid=%0b out=%h fr=%0b, required 0 0 0 1", mask_count, grad_out_valid, grad_out, fwd_ready);
    end
    $display("midstream: reset and flush cleared, count=%0d", mask_count);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; fwd_valid = 1'b0; fwd_in = '0;
    grad_in_valid = 1'b0; grad_in = '0; grad_out_ready = 1'b1;
    model_clear();
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b1;
    @(negedge clock);
    test_basic();
    test_full();
    test_backpressure();
    test_wrap();
    test_empty();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
